// File: rtl/trace_buffer.sv
// Retire-stage trace capture: a circular store of retired-instruction records, drained over valid/ready.
// Optional PC trigger (ARMED state, i_trigPc port) is compiled in with `define TRACE_TRIGGER_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | capture off, nothing stored
// S_ARMED   | waiting for retire at i_trigPc (TRACE_TRIGGER_EN only)
// S_CAPTURE | every valid retire is pushed
// S_HALTED  | halt instruction seen; reads only, left via clear/reset

module trace_buffer #(
  parameter int          DEPTH     = 16,
  parameter bit          OVERWRITE = 1'b0,
  parameter logic [31:0] HALT_INST = 32'h0000_006F
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_clear,
  input  logic [31:0]                i_tick,
  input  logic                       i_isValid,
  input  logic [31:0]                i_pc,
  input  logic [31:0]                i_inst,
  input  logic [4:0]                 i_regWrAddr,
  input  logic                       i_regWrEnable,
  input  logic [31:0]                i_regWrData,
  input  logic [31:0]                i_memWrAddr,
  input  logic                       i_memWrEnable,
  input  logic [1:0]                 i_memAccess,
  input  logic [31:0]                i_memWrData,
`ifdef TRACE_TRIGGER_EN
  input  logic [31:0]                i_trigPc,
`endif
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [31:0]                o_tick,
  output logic [31:0]                o_pc,
  output logic [31:0]                o_inst,
  output logic [4:0]                 o_regWrAddr,
  output logic                       o_regWrEnable,
  output logic [31:0]                o_regWrData,
  output logic [31:0]                o_memWrAddr,
  output logic                       o_memWrEnable,
  output logic [1:0]                 o_memAccess,
  output logic [31:0]                o_memWrData,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [15:0]                o_dropCount,
  output logic                       o_halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

`ifdef TRACE_TRIGGER_EN
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HALTED, S_ARMED} state_t;
  localparam state_t S_START = S_ARMED;
`else
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HALTED} state_t;
  localparam state_t S_START = S_CAPTURE;
`endif

  state_t          state_q;
  state_t          state_d;
  logic            push;
  logic            pop;
  logic            full;
  logic            wr_en;
  logic            drop_evt;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;
  logic [15:0]     drop_q;

  logic [31:0]     mem_tick  [DEPTH];
  logic [31:0]     mem_pc    [DEPTH];
  logic [31:0]     mem_inst  [DEPTH];
  logic [4:0]      mem_ra    [DEPTH];
  logic            mem_re    [DEPTH];
  logic [31:0]     mem_rd    [DEPTH];
  logic [31:0]     mem_ma    [DEPTH];
  logic            mem_me    [DEPTH];
  logic [1:0]      mem_macc  [DEPTH];
  logic [31:0]     mem_md    [DEPTH];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Push is decided here so that the trigger record can be taken from ARMED.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_START;
      end
`ifdef TRACE_TRIGGER_EN
      S_ARMED: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if (i_isValid && (i_pc == i_trigPc)) begin
          push    = 1'b1;
          state_d = S_CAPTURE;
        end
      end
`endif
      S_CAPTURE: begin
        push = i_isValid;
        if (i_isValid && (i_inst == HALT_INST)) begin
          state_d = S_HALTED;
        end else if (!i_enable) begin
          state_d = S_IDLE;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (i_clear) begin
      push    = 1'b0;
      state_d = S_IDLE;
    end
  end

  assign o_valid  = (count_q != '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = o_valid & i_ready & ~i_clear;
  // A full buffer still accepts a push when a pop frees the head slot in the same cycle.
  assign wr_en    = push & (~full | pop | OVERWRITE);
  assign drop_evt = push & full & ~pop;

  always_ff @(posedge i_clock) begin
    if (wr_en) begin
      mem_tick[wr_ptr] <= i_tick;
      mem_pc[wr_ptr]   <= i_pc;
      mem_inst[wr_ptr] <= i_inst;
      mem_ra[wr_ptr]   <= i_regWrAddr;
      mem_re[wr_ptr]   <= i_regWrEnable & (i_regWrAddr != 5'd0);
      mem_rd[wr_ptr]   <= i_regWrData;
      mem_ma[wr_ptr]   <= i_memWrAddr;
      mem_me[wr_ptr]   <= i_memWrEnable;
      mem_macc[wr_ptr] <= i_memAccess;
      mem_md[wr_ptr]   <= i_memWrData;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else if (i_clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop | (drop_evt & OVERWRITE)) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en & ~pop & ~full) begin
        count_q <= count_q + CW'(1);
      end else if (pop & ~wr_en) begin
        count_q <= count_q - CW'(1);
      end
      if (drop_evt && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // Storage is not reset, so head fields are masked while the buffer is empty.
  assign o_tick        = o_valid ? mem_tick[rd_ptr] : '0;
  assign o_pc          = o_valid ? mem_pc[rd_ptr]   : '0;
  assign o_inst        = o_valid ? mem_inst[rd_ptr] : '0;
  assign o_regWrAddr   = o_valid ? mem_ra[rd_ptr]   : '0;
  assign o_regWrEnable = o_valid & mem_re[rd_ptr];
  assign o_regWrData   = o_valid ? mem_rd[rd_ptr]   : '0;
  assign o_memWrAddr   = o_valid ? mem_ma[rd_ptr]   : '0;
  assign o_memWrEnable = o_valid & mem_me[rd_ptr];
  assign o_memAccess   = o_valid ? mem_macc[rd_ptr] : '0;
  assign o_memWrData   = o_valid ? mem_md[rd_ptr]   : '0;

  assign o_count     = count_q;
  assign o_dropCount = drop_q;
  assign o_halted    = (state_q == S_HALTED);

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: drop-newest and overwrite-oldest instances share one stimulus stream,
// each checked every cycle against a queue model; literal checks pin the model on fixed scenarios.

module tb_trace_buffer;

  localparam int          DEPTH = 16;
  localparam logic [31:0] HALT  = 32'h0000_006F;
`ifdef TRACE_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] tick;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  ra;
    logic        re;
    logic [31:0] rd;
    logic [31:0] ma;
    logic        me;
    logic [1:0]  macc;
    logic [31:0] md;
  } rec_t;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_enable = 1'b0, i_clear = 1'b0, i_isValid = 1'b0, i_ready = 1'b0;
  logic [31:0] i_tick = '0, i_pc = '0, i_inst = '0, i_regWrData = '0;
  logic [31:0] i_memWrAddr = '0, i_memWrData = '0, i_trigPc = 32'h100;
  logic [4:0]  i_regWrAddr = '0;
  logic        i_regWrEnable = 1'b0, i_memWrEnable = 1'b0;
  logic [1:0]  i_memAccess = '0;

  logic [1:0]        o_valid, o_regWrEnable, o_memWrEnable, o_halted;
  logic [1:0][31:0]  o_tick, o_pc, o_inst, o_regWrData, o_memWrAddr, o_memWrData;
  logic [1:0][4:0]   o_regWrAddr, o_count;
  logic [1:0][1:0]   o_memAccess;
  logic [1:0][15:0]  o_dropCount;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clock = ~i_clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    trace_buffer #(.DEPTH(DEPTH), .OVERWRITE(g == 1), .HALT_INST(HALT)) u_dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_clear),
      .i_tick(i_tick), .i_isValid(i_isValid), .i_pc(i_pc), .i_inst(i_inst),
      .i_regWrAddr(i_regWrAddr), .i_regWrEnable(i_regWrEnable), .i_regWrData(i_regWrData),
      .i_memWrAddr(i_memWrAddr), .i_memWrEnable(i_memWrEnable), .i_memAccess(i_memAccess),
      .i_memWrData(i_memWrData),
`ifdef TRACE_TRIGGER_EN
      .i_trigPc(i_trigPc),
`endif
      .i_ready(i_ready), .o_valid(o_valid[g]), .o_tick(o_tick[g]), .o_pc(o_pc[g]),
      .o_inst(o_inst[g]), .o_regWrAddr(o_regWrAddr[g]), .o_regWrEnable(o_regWrEnable[g]),
      .o_regWrData(o_regWrData[g]), .o_memWrAddr(o_memWrAddr[g]),
      .o_memWrEnable(o_memWrEnable[g]), .o_memAccess(o_memAccess[g]),
      .o_memWrData(o_memWrData[g]), .o_count(o_count[g]), .o_dropCount(o_dropCount[g]),
      .o_halted(o_halted[g])
    );
  end

  // Reference model: one record queue per instance; mode 0 idle, 1 capture, 2 halted, 3 armed.
  rec_t mq[2][$];
  int   mdrop[2] = '{0, 0};
  int   mmode = 0;

  task automatic check(input string name, input int k, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mdrop[k] = 0;
    end
    mmode = 0;
  endtask

  task automatic model_step();
    rec_t r;
    bit   do_push;
    int   nmode;
    if (i_clear) begin
      model_reset();
      return;
    end
    r = {i_tick, i_pc, i_inst, i_regWrAddr, i_regWrEnable && (i_regWrAddr != 0),
         i_regWrData, i_memWrAddr, i_memWrEnable, i_memAccess, i_memWrData};
    do_push = 1'b0;
    nmode   = mmode;
    case (mmode)
      0: if (i_enable) nmode = TRIG ? 3 : 1;
      3: begin
        if (!i_enable) nmode = 0;
        else if (i_isValid && i_pc == i_trigPc) begin
          do_push = 1'b1;
          nmode   = 1;
        end
      end
      1: begin
        do_push = i_isValid;
        if (i_isValid && i_inst == HALT) nmode = 2;
        else if (!i_enable) nmode = 0;
      end
      default: ;
    endcase
    for (int k = 0; k < 2; k++) begin
      if (mq[k].size() != 0 && i_ready) void'(mq[k].pop_front());
      if (do_push) begin
        if (mq[k].size() < DEPTH) mq[k].push_back(r);
        else begin
          if (k == 1) begin
            void'(mq[k].pop_front());
            mq[k].push_back(r);
          end
          if (mdrop[k] < 65535) mdrop[k]++;
        end
      end
    end
    mmode = nmode;
  endtask

  task automatic compare_all();
    rec_t a, e;
    for (int k = 0; k < 2; k++) begin
      a = {o_tick[k], o_pc[k], o_inst[k], o_regWrAddr[k], o_regWrEnable[k], o_regWrData[k],
           o_memWrAddr[k], o_memWrEnable[k], o_memAccess[k], o_memWrData[k]};
      e = (mq[k].size() != 0) ? mq[k][0] : '0;
      check("valid", k, o_valid[k], mq[k].size() != 0);
      check("count", k, o_count[k], mq[k].size());
      check("drops", k, o_dropCount[k], mdrop[k]);
      check("halted", k, o_halted[k], mmode == 2);
      check("head", k, a, e);
    end
  endtask

  always @(negedge i_reset) model_reset();
  always @(posedge i_clock) if (i_reset) model_step();
  always @(posedge i_clock) begin
    #1;
    compare_all();
  end

  task automatic cyc();
    @(negedge i_clock);
  endtask

  task automatic put_rec(input logic [31:0] tick, input logic [31:0] pc);
    i_isValid     = 1'b1;
    i_tick        = tick;
    i_pc          = pc;
    i_inst        = $urandom | 32'h100;
    i_regWrAddr   = 5'($urandom_range(1, 31));
    i_regWrEnable = 1'($urandom);
    i_regWrData   = $urandom;
    i_memWrAddr   = $urandom;
    i_memWrEnable = 1'($urandom);
    i_memAccess   = 2'($urandom);
    i_memWrData   = $urandom;
  endtask

  initial begin
    #23 i_reset = 1'b1;

    // basic push then ordered drain
    cyc();
    i_enable = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      put_rec(i + 1, 32'h100 + 4 * i);
      cyc();
    end
    i_isValid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("t1_count", k, o_count[k], 3);
      check("t1_valid", k, o_valid[k], 1);
      check("t1_pc0", k, o_pc[k], 32'h100);
    end
    i_ready = 1'b1;
    cyc();
    for (int k = 0; k < 2; k++) check("t1_pc1", k, o_pc[k], 32'h104);
    cyc();
    for (int k = 0; k < 2; k++) check("t1_pc2", k, o_pc[k], 32'h108);
    cyc();
    for (int k = 0; k < 2; k++) check("t1_empty", k, o_count[k], 0);
    i_ready = 1'b0;

    // overflow: drop-newest vs overwrite-oldest
    for (int i = 0; i < 20; i++) begin
      put_rec(i + 1, 32'h100 + 4 * i);
      cyc();
    end
    i_isValid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("t2_count", k, o_count[k], 16);
      check("t2_drops", k, o_dropCount[k], 4);
      check("t2_head", k, o_tick[k], (k == 0) ? 1 : 5);
    end

    // full with simultaneous push and pop
    put_rec(100, 32'h300);
    i_ready = 1'b1;
    cyc();
    i_isValid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("t3_count", k, o_count[k], 16);
      check("t3_drops", k, o_dropCount[k], 4);
    end
    repeat (15) cyc();
    for (int k = 0; k < 2; k++) begin
      check("t3_tail", k, o_tick[k], 100);
      check("t3_last", k, o_count[k], 1);
    end
    cyc();
    i_ready = 1'b0;

    // x0 write normalisation, halt, clear
    put_rec(200, 32'h400);
    i_regWrAddr   = 5'd0;
    i_regWrEnable = 1'b1;
    cyc();
    i_isValid = 1'b0;
    for (int k = 0; k < 2; k++) check("t4_x0we", k, o_regWrEnable[k], 0);
    put_rec(201, 32'h404);
    i_inst = HALT;
    cyc();
    i_isValid = 1'b0;
    for (int k = 0; k < 2; k++) check("t4_halt", k, o_halted[k], 1);
    for (int i = 0; i < 3; i++) begin
      put_rec(300 + i, 32'h500);
      cyc();
    end
    i_isValid = 1'b0;
    for (int k = 0; k < 2; k++) check("t4_frozen", k, o_count[k], 2);
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("t4_clr_cnt", k, o_count[k], 0);
      check("t4_clr_halt", k, o_halted[k], 0);
    end

    // asynchronous reset mid-stream
    cyc();
    for (int i = 0; i < 5; i++) begin
      put_rec(400 + i, 32'h100 + 4 * i);
      cyc();
    end
    i_isValid = 1'b0;
    for (int k = 0; k < 2; k++) check("t5_count", k, o_count[k], 5);
    #2 i_reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("t5_rst_valid", k, o_valid[k], 0);
      check("t5_rst_count", k, o_count[k], 0);
      check("t5_rst_pc", k, o_pc[k], 0);
    end
    #1 i_reset = 1'b1;
    cyc();
    for (int k = 0; k < 2; k++) begin
      check("t5_post_valid", k, o_valid[k], 0);
      check("t5_post_drops", k, o_dropCount[k], 0);
    end

`ifdef TRACE_TRIGGER_EN
    // trigger on a PC
    i_clear = 1'b1;
    cyc();
    i_clear  = 1'b0;
    i_trigPc = 32'h200;
    cyc();
    for (int i = 0; i < 4; i++) begin
      put_rec(500 + i, 32'h1F8 + 4 * i);
      cyc();
    end
    i_isValid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("t6_count", k, o_count[k], 2);
      check("t6_pc", k, o_pc[k], 32'h200);
      check("t6_drops", k, o_dropCount[k], 0);
    end
    i_trigPc = 32'h100;
`endif

    // randomized traffic
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      put_rec(32'(c), ($urandom_range(0, 7) == 0) ? i_trigPc : $urandom);
      i_isValid   = ($urandom_range(0, 2) != 0);
      i_regWrAddr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) i_inst = HALT;
      i_enable = ($urandom_range(0, 19) != 0);
      i_ready  = (c < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      i_clear  = ($urandom_range(0, 79) == 0);
      cyc();
    end
    i_isValid = 1'b0;
    i_clear   = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
- Capture buffer directly downstream of the core's retire stage.
- Records each valid retired instruction (tick, PC, instruction, register write, memory write) into a circular store. A host/debug reader drains it over a valid/ready handshake.
- Retire side never stalls; overflow is counted, never back-pressured.
- A small capture FSM handles enable, halt detection (self-loop `jal x0,0`) and clear.

Parameters:
- DEPTH, 16, number of records; power of two, ≥2.
- OVERWRITE, 0, 0 = drop newest when full; 1 = overwrite oldest when full.
- HALT_INST, 32'h0000006F, instruction encoding that ends capture.

Ports:
- i_clock  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- i_enable  in  1  capture enable, level.
- i_clear  in  1  sync flush: empties buffer, zeroes drop count, FSM→IDLE.
- i_tick  in  32  tick number of the retiring instruction.
- i_isValid  in  1  a valid instruction retires this cycle.
- i_pc  in  32  InstAddr of the retiring instruction.
- i_inst  in  32  Inst.
- i_regWrAddr  in  5  GPRAddr.
- i_regWrEnable  in  1  register write enable.
- i_regWrData  in  32  Data.
- i_memWrAddr  in  32  DataAddr.
- i_memWrEnable  in  1  memory write enable.
- i_memAccess  in  2  DataAccess (byte/half/word).
- i_memWrData  in  32  Data.
- i_ready  in  1  reader accepts the head record.
- o_valid  out  1  head record available.
- o_tick, o_pc, o_inst, o_regWrAddr, o_regWrEnable, o_regWrData, o_memWrAddr, o_memWrEnable, o_memAccess, o_memWrData  out  same widths as inputs  head record fields.
- o_count  out  $clog2(DEPTH)+1  records held.
- o_dropCount  out  16  records lost to overflow, saturating at 16'hFFFF.
- o_halted  out  1  FSM in HALTED.

Behaviour:

Reset (i_reset=0, async):
- FSM=IDLE; rd/wr pointers=0.
- o_count=0, o_valid=0, o_dropCount=0, o_halted=0.
- Head-record outputs=0.

Push condition:
- push = state==CAPTURE & i_isValid & ~i_clear.
- Exception: when the trigger option is compiled in, the trigger record is pushed from ARMED (see Optional Feature).

Pop, head outputs and latency:
- pop = o_valid & i_ready.
- o_valid = (o_count != 0).
- Head fields are combinational from storage at the read pointer.
- Push-to-visible latency is 1 cycle: a record pushed at edge N appears at o_valid after N. No fall-through.

Normalisation on push:
- If i_regWrAddr==0, the stored regWrEnable is 0.
- All other fields are stored verbatim.

Full, no pop:
- OVERWRITE=0: the push is dropped and o_dropCount increments.
- OVERWRITE=1: the oldest record is overwritten; both pointers advance; o_count stays DEPTH; o_dropCount increments.

Boundary cases:
- Full with push and pop in the same cycle: the push is accepted in both modes; o_count unchanged; no drop.
- Empty with push and pop in the same cycle: impossible, since o_valid=0.
- Pointers wrap modulo DEPTH.

FSM states:
- IDLE:
  - i_enable=1 → CAPTURE.
  - No pushes.
- CAPTURE:
  - i_enable=0 → IDLE.
  - A pushed record with i_inst==HALT_INST → HALTED. That record is stored.
- HALTED:
  - No pushes; reads continue; o_halted=1.
  - Leaves only via i_clear or reset.

Priorities:
- i_clear (sync): highest priority. Pointers=0, count=0, drops=0, FSM→IDLE. Any same-cycle push and pop are ignored.
- Reset asserted mid-operation: all state is lost immediately. No partial record remains after release.

Optional Feature:

Macro: TRACE_TRIGGER_EN

Defined:
- Adds input i_trigPc (32) and FSM state ARMED.
- IDLE with i_enable=1 → ARMED.
- In ARMED, i_enable=0 → IDLE.
- In ARMED, i_isValid & i_pc==i_trigPc → CAPTURE. The triggering record is pushed in that same cycle.
- Records before the trigger are not stored and are not counted as drops.

Undefined:
- No i_trigPc port and no ARMED state.
- IDLE goes directly to CAPTURE.

Test Plan:
1. Reset, i_enable=1, push 3 records (tick 1..3, pc 0x100/0x104/0x108), i_ready=0 → o_count=3, o_valid=1, o_pc=0x100. Then i_ready=1 for 3 cycles → pcs 0x100, 0x104, 0x108 in order, o_count=0.
2. OVERWRITE=0, DEPTH=16, i_ready=0, push 20 records → o_count=16, o_dropCount=4, head tick=1. Repeat with OVERWRITE=1 → o_dropCount=4, head tick=5.
3. Buffer full, push and pop in the same cycle → o_count stays 16, o_dropCount unchanged, new tail record present after draining.
4. Push record with i_regWrAddr=0, i_regWrEnable=1 → stored o_regWrEnable=0. Then push i_inst=32'h0000006F → o_halted=1 next cycle; later i_isValid pulses add nothing. Then i_clear → o_count=0, o_halted=0.
5. Assert i_reset=0 mid-stream with o_count=5, not aligned to a clock edge → outputs zero immediately. After release, o_valid=0 and o_dropCount=0.
6. TRACE_TRIGGER_EN, i_trigPc=0x200, retire pcs 0x1F8, 0x1FC, 0x200, 0x204 → o_count=2, head pc=0x200, o_dropCount=0.
